// File: rtl/decode_issue_unit_pkg.sv
// decode_issue_unit_pkg: opcode constants, field helpers, instruction-class predicates and FSM encodings
package decode_issue_unit_pkg;
  typedef enum logic [1:0] {RUN, HOLD_ONE, HOLD_PAIR} state_t;
  typedef enum logic [1:0] {A_FLUSH, A_HOLD, A_SPLIT, A_BOTH} act_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SRL = 4'h7;
  localparam logic [3:0] OP_LD = 4'h9;
  localparam logic [3:0] OP_ST = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  function automatic logic [3:0] op_of(input logic [15:0] i);
    return i[15:12];
  endfunction
  function automatic logic [3:0] rd_of(input logic [15:0] i);
    return i[11:8];
  endfunction
  function automatic logic [3:0] rs1_of(input logic [15:0] i);
    return i[7:4];
  endfunction
  function automatic logic [3:0] rs2_of(input logic [15:0] i);
    return i[3:0];
  endfunction
  function automatic logic is_nop(input logic [3:0] op);
    return op == OP_NOP || op > OP_JMP;
  endfunction
  function automatic logic is_alu(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_SRL;
  endfunction
  function automatic logic is_writer(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_LD;
  endfunction
  function automatic logic reads_rs1(input logic [3:0] op);
    return is_alu(op) || (op >= OP_LD && op <= OP_BEQ);
  endfunction
  function automatic logic reads_rs2(input logic [3:0] op);
    return is_alu(op) || op == OP_ST || op == OP_BEQ;
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op == OP_LD || op == OP_ST;
  endfunction
  function automatic logic is_ctrl(input logic [3:0] op);
    return op == OP_BEQ || op == OP_JMP;
  endfunction
endpackage

// File: rtl/decode_issue_unit_if.sv
// decode_issue_unit_if: fetch->decode pair, execute feedback and the two issue lanes
interface decode_issue_unit_if;
  logic [15:0] instr1;
  logic [15:0] instr2;
  logic is_branch_taken;
  logic ex_stall;
  logic stall;
  logic issingleinstr;
  logic iss0_valid;
  logic [15:0] iss0_instr;
  logic iss0_we;
  logic iss1_valid;
  logic [15:0] iss1_instr;
  logic iss1_we;
  modport master (
    output instr1, instr2, is_branch_taken, ex_stall,
    input stall, issingleinstr, iss0_valid, iss0_instr, iss0_we, iss1_valid, iss1_instr, iss1_we
  );
  modport slave (
    input instr1, instr2, is_branch_taken, ex_stall,
    output stall, issingleinstr, iss0_valid, iss0_instr, iss0_we, iss1_valid, iss1_instr, iss1_we
  );
endinterface

// File: rtl/decode_issue_unit_load_scoreboard.sv
// load_scoreboard: per-register countdown of in-flight load latency, queried by both issue lanes
module load_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int LOAD_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [3:0] set_rd,
  input  logic [3:0] q0_rs1,
  input  logic [3:0] q0_rs2,
  input  logic [1:0] q0_en,
  input  logic [3:0] q1_rs1,
  input  logic [3:0] q1_rs2,
  input  logic [1:0] q1_en,
  output logic       busy0,
  output logic       busy1
);
  logic [1:0] cnt [NUM_REGS];
  // a load issue arms its destination; armed counters drain one per cycle
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    else
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= (set_en && set_rd == 4'(i)) ? 2'(LOAD_LAT - 1) : cnt[i] - {1'b0, |cnt[i]};
  assign busy0 = (q0_en[0] && cnt[q0_rs1] != '0) || (q0_en[1] && cnt[q0_rs2] != '0);
  assign busy1 = (q1_en[0] && cnt[q1_rs1] != '0) || (q1_en[1] && cnt[q1_rs2] != '0);
endmodule

// File: rtl/decode_issue_unit.sv
// decode_issue_unit: dual-issue decode with pair splitting, load-use blocking and branch flush.
// Optional SINGLE_ISSUE_FALLBACK_EN asks fetch for single-instruction mode after repeated splits.
module decode_issue_unit
  import decode_issue_unit_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int LOAD_LAT = 2
`ifdef SINGLE_ISSUE_FALLBACK_EN
  ,
  parameter int SPLIT_THRESH = 4,
  parameter int FALLBACK_CYCLES = 8
`endif
) (
  input logic clk,
  input logic reset,
  decode_issue_unit_if.slave bus
);
  state_t st, st_n;
  act_t act;
  logic [15:0] p0, p1, p0_n, p1_n, c0, c1;
  logic [3:0] o0, o1;
  logic fb, split, blk0, blk1, v0, v1, ld0, ld1;
  assign c0 = (st == RUN) ? bus.instr1 : p0;
  assign c1 = (st != RUN) ? p1 : fb ? '0 : bus.instr2;
  assign o0 = op_of(c0);
  assign o1 = op_of(c1);
  load_scoreboard #(.NUM_REGS(NUM_REGS), .LOAD_LAT(LOAD_LAT)) u_sb (
    .clk(clk),
    .reset(reset),
    .set_en(ld0 || ld1),
    .set_rd(ld0 ? rd_of(c0) : rd_of(c1)),
    .q0_rs1(rs1_of(c0)),
    .q0_rs2(rs2_of(c0)),
    .q0_en({reads_rs2(o0), reads_rs1(o0)}),
    .q1_rs1(rs1_of(c1)),
    .q1_rs2(rs2_of(c1)),
    .q1_en({reads_rs2(o1), reads_rs1(o1)}),
    .busy0(blk0),
    .busy1(blk1)
  );
  // pair hazards, action priority, next state, pending slots and lane valids
  always_comb begin
    split = !is_nop(o0) && !is_nop(o1) &&
            ((is_writer(o0) && ((reads_rs1(o1) && rs1_of(c1) == rd_of(c0)) ||
                                (reads_rs2(o1) && rs2_of(c1) == rd_of(c0)) ||
                                (is_writer(o1) && rd_of(c1) == rd_of(c0)))) ||
             (is_mem(o0) && is_mem(o1)) || is_ctrl(o0));
    act = bus.is_branch_taken ? A_FLUSH : (bus.ex_stall || blk0) ? A_HOLD : (split || blk1) ? A_SPLIT : A_BOTH;
    st_n = (act == A_HOLD) ? HOLD_PAIR : (act == A_SPLIT) ? HOLD_ONE : RUN;
    p0_n = (act == A_HOLD) ? c0 : (act == A_SPLIT) ? c1 : '0;
    p1_n = (act == A_HOLD) ? c1 : '0;
    v0 = (act == A_SPLIT || act == A_BOTH) && !is_nop(o0);
    v1 = (act == A_BOTH) && !is_nop(o1);
    ld0 = v0 && o0 == OP_LD;
    ld1 = v1 && o1 == OP_LD;
  end
  assign bus.stall = !reset && (act == A_HOLD || act == A_SPLIT);
  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= RUN;
    else st <= st_n;
  // pending pair and registered issue lanes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p0 <= '0;
      p1 <= '0;
      bus.iss0_valid <= 1'b0;
      bus.iss0_instr <= '0;
      bus.iss0_we <= 1'b0;
      bus.iss1_valid <= 1'b0;
      bus.iss1_instr <= '0;
      bus.iss1_we <= 1'b0;
    end else begin
      p0 <= p0_n;
      p1 <= p1_n;
      bus.iss0_valid <= v0;
      bus.iss0_instr <= v0 ? c0 : '0;
      bus.iss0_we <= v0 && is_writer(o0);
      bus.iss1_valid <= v1;
      bus.iss1_instr <= v1 ? c1 : '0;
      bus.iss1_we <= v1 && is_writer(o1);
    end
`ifdef SINGLE_ISSUE_FALLBACK_EN
  logic [7:0] sp_cnt, fb_cnt;
  // consecutive hazard splits arm a fixed-length single-issue window
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fb <= 1'b0;
      sp_cnt <= '0;
      fb_cnt <= '0;
    end else if (fb) begin
      fb_cnt <= fb_cnt - 8'd1;
      if (fb_cnt == 8'd1) begin
        fb <= 1'b0;
        sp_cnt <= '0;
      end
    end else if (act == A_SPLIT && split) begin
      if (sp_cnt == 8'(SPLIT_THRESH - 1)) begin
        fb <= 1'b1;
        fb_cnt <= 8'(FALLBACK_CYCLES);
      end else sp_cnt <= sp_cnt + 8'd1;
    end else if (act == A_BOTH && !is_nop(o0) && !is_nop(o1)) sp_cnt <= '0;
  assign bus.issingleinstr = fb;
`else
  assign fb = 1'b0;
  assign bus.issingleinstr = 1'b0;
`endif
endmodule

// File: tb/tb_decode_issue_unit.sv
// tb_decode_issue_unit: directed checks of issue, split, load-use, backpressure, flush and reset
module tb_decode_issue_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int hi = 0;
`ifdef SINGLE_ISSUE_FALLBACK_EN
  localparam int EXP_HI = 8;
`else
  localparam int EXP_HI = 0;
`endif
  decode_issue_unit_if bus();
  decode_issue_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b, input logic br,
                      input logic es, input logic st, input logic v0, input logic [15:0] e0,
                      input logic v1, input logic [15:0] e1);
    bus.instr1 = a;
    bus.instr2 = b;
    bus.is_branch_taken = br;
    bus.ex_stall = es;
    #2;
    chk({tag, "_stall"}, 40'(bus.stall), 40'(st));
    tick;
    chk({tag, "_lanes"}, 40'({bus.iss0_valid, bus.iss0_instr, bus.iss1_valid, bus.iss1_instr}), 40'({v0, e0, v1, e1}));
  endtask
  initial begin
    reset = 1'b1;
    bus.instr1 = '0;
    bus.instr2 = '0;
    bus.is_branch_taken = 1'b0;
    bus.ex_stall = 1'b1;
    tick;
    tick;
    #2;
    chk("rst_stall", 40'(bus.stall), 40'd0);
    chk("rst_lanes", 40'({bus.iss0_valid, bus.iss0_instr, bus.iss1_valid, bus.iss1_instr, bus.iss0_we, bus.iss1_we}), 40'd0);
    chk("rst_single", 40'(bus.issingleinstr), 40'd0);
    reset = 1'b0;
    bus.ex_stall = 1'b0;
    tick;
    step("dual", 16'h1123, 16'h2456, 0, 0, 0, 1, 16'h1123, 1, 16'h2456);
    chk("dual_we", 40'({bus.iss0_we, bus.iss1_we}), 40'b11);
    step("idle", 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    step("raw1", 16'h1123, 16'h5415, 0, 0, 1, 1, 16'h1123, 0, 16'h0);
    step("raw2", 16'h0, 16'h0, 0, 0, 0, 1, 16'h5415, 0, 16'h0);
    step("ld", 16'h9120, 16'h0, 0, 0, 0, 1, 16'h9120, 0, 16'h0);
    chk("ld_we", 40'(bus.iss0_we), 40'd1);
    step("use1", 16'h1311, 16'h0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
    step("use2", 16'h0, 16'h0, 0, 0, 0, 1, 16'h1311, 0, 16'h0);
    step("exs1", 16'h8155, 16'h8266, 0, 1, 1, 0, 16'h0, 0, 16'h0);
    step("exs2", 16'h0, 16'h0, 0, 1, 1, 0, 16'h0, 0, 16'h0);
    step("exs3", 16'h0, 16'h0, 0, 1, 1, 0, 16'h0, 0, 16'h0);
    step("exs4", 16'h0, 16'h0, 0, 0, 0, 1, 16'h8155, 1, 16'h8266);
    chk("exs_we", 40'({bus.iss0_we, bus.iss1_we}), 40'b11);
    step("br1", 16'h1123, 16'h5415, 0, 0, 1, 1, 16'h1123, 0, 16'h0);
    step("br2", 16'h0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 16'h0);
    step("br3", 16'h8155, 16'h8266, 0, 0, 0, 1, 16'h8155, 1, 16'h8266);
    step("br4", 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    step("waw1", 16'h8155, 16'h8166, 0, 0, 1, 1, 16'h8155, 0, 16'h0);
    step("waw2", 16'h0, 16'h0, 0, 0, 0, 1, 16'h8166, 0, 16'h0);
    step("mem1", 16'h9120, 16'hA034, 0, 0, 1, 1, 16'h9120, 0, 16'h0);
    step("mem2", 16'h0, 16'h0, 0, 0, 0, 1, 16'hA034, 0, 16'h0);
    chk("st_we", 40'(bus.iss0_we), 40'd0);
    step("ctl1", 16'hC000, 16'h1123, 0, 0, 1, 1, 16'hC000, 0, 16'h0);
    step("ctl2", 16'h0, 16'h0, 0, 0, 0, 1, 16'h1123, 0, 16'h0);
    step("nop0", 16'h0, 16'h1123, 0, 0, 0, 0, 16'h0, 1, 16'h1123);
    step("nopf", 16'hF123, 16'h8155, 0, 0, 0, 0, 16'h0, 1, 16'h8155);
    step("ld_l1", 16'h8155, 16'h9230, 0, 0, 0, 1, 16'h8155, 1, 16'h9230);
    chk("ld_l1_we", 40'({bus.iss0_we, bus.iss1_we}), 40'b11);
    step("blk1a", 16'h8766, 16'h1520, 0, 0, 1, 1, 16'h8766, 0, 16'h0);
    step("blk1b", 16'h0, 16'h0, 0, 0, 0, 1, 16'h1520, 0, 16'h0);
    step("brx", 16'h8155, 16'h8266, 1, 1, 0, 0, 16'h0, 0, 16'h0);
    step("rh1", 16'h1123, 16'h5415, 0, 0, 1, 1, 16'h1123, 0, 16'h0);
    reset = 1'b1;
    #1;
    chk("rh_stall", 40'(bus.stall), 40'd0);
    chk("rh_lanes", 40'({bus.iss0_valid, bus.iss0_instr, bus.iss1_valid, bus.iss1_instr}), 40'd0);
    tick;
    reset = 1'b0;
    step("rh2", 16'h0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    step("fb_pre", 16'h8155, 16'h8266, 0, 0, 0, 1, 16'h8155, 1, 16'h8266);
    for (int k = 0; k < 4; k++) begin
      step("fb_sp", 16'h1123, 16'h5415, 0, 0, 1, 1, 16'h1123, 0, 16'h0);
      hi += int'(bus.issingleinstr);
      step("fb_h1", 16'h0, 16'h0, 0, 0, 0, 1, 16'h5415, 0, 16'h0);
      hi += int'(bus.issingleinstr);
    end
    for (int k = 0; k < 20; k++) begin
      tick;
      hi += int'(bus.issingleinstr);
    end
    chk("fb_cycles", 40'(hi), 40'(EXP_HI));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
